// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths,
// execute-to-mem field layout, load/store size encodings and load-state names.
package mem_stage_pkg;

    localparam int EX_TO_MEM_BUS_WD = 108;
    localparam int MEM_TO_WB_BUS_WD = 70;
    localparam int RDW_BUS_WD       = 39;

    // Load/store size encodings carried in ls_type; bit 2 selects zero-extension.
    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    // Execute-to-mem bus, MSB first; 32+32+1+1+3+1+1+5+32 = 108 bits.
    typedef struct packed {
        logic [31:0] rs2_value;
        logic [31:0] result;
        logic        load_wen;
        logic        store_wen;
        logic [2:0]  ls_type;
        logic        mem_wen;
        logic        wb_wen;
        logic [4:0]  dest;
        logic [31:0] pc;
    } ex_bus_t;

    // Per-instruction load progress: WAIT has no data yet, HELD owns buffered data.
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_WAIT = 2'd1,
        LD_HELD = 2'd2
    } ld_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  ls_type,
    output logic [31:0] extended
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the raw word.
    always_comb begin
        byte_s = raw[7:0];
        case (offset)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = raw[7:0];
        endcase
        if (offset[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
    end

    // Extend according to the access size; unknown encodings yield zero.
    always_comb begin
        extended = 32'd0;
        case (ls_type)
            LS_LB:   extended = {{24{byte_s[7]}}, byte_s};
            LS_LBU:  extended = {24'd0, byte_s};
            LS_LH:   extended = {{16{half_s[15]}}, half_s};
            LS_LHU:  extended = {16'd0, half_s};
            LS_LW:   extended = raw;
            default: extended = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, waits for
// load data when needed (buffering it under writeback backpressure), aligns
// it and forwards the result to writeback and to the decode bypass bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_allowin,
    output logic                          mem_allowin,
    input  logic                          ex_to_mem_valid,
    input  logic [EX_TO_MEM_BUS_WD-1:0]   ex_to_mem_bus,
    output logic                          mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]   mem_to_wb_bus,
    input  logic [31:0]                   Read_data,
    input  logic                          Read_data_Valid,
    output logic                          Read_data_Ready,
    output logic [RDW_BUS_WD-1:0]         rdw_mem_bus
);

    ex_bus_t     ex_in_s;
    ex_bus_t     ex_bus_r;
    logic        mem_valid_r;
    ld_state_e   state_r;
    ld_state_e   state_nxt_s;
    logic [31:0] data_buf_r;

    logic        data_got_s;
    logic        mem_ready_go_s;
    logic        mem_allowin_s;
    logic        enter_s;
    logic        rd_ready_s;
    logic        capture_s;
    logic [31:0] raw_s;
    logic [31:0] extended_s;
    logic [31:0] wb_data_s;
    logic        unused_fields_s;

    assign ex_in_s = ex_bus_t'(ex_to_mem_bus);

    // Store-side fields travel with the instruction but are not consumed here.
    assign unused_fields_s = ^{ex_bus_r.rs2_value, ex_bus_r.store_wen, ex_bus_r.mem_wen};

    assign data_got_s     = (state_r == LD_HELD);
    assign mem_ready_go_s = !ex_bus_r.load_wen | data_got_s | Read_data_Valid;
    assign mem_allowin_s  = !mem_valid_r | (mem_ready_go_s & wb_allowin);
    assign enter_s        = ex_to_mem_valid & mem_allowin_s;
    assign rd_ready_s     = mem_valid_r & ex_bus_r.load_wen & !data_got_s;
    // Data arriving while writeback can take it flows straight through instead.
    assign capture_s      = Read_data_Valid & rd_ready_s & !wb_allowin;

    // Load-progress next state; a handoff or new entry always wins over a capture.
    always_comb begin
        state_nxt_s = state_r;
        if (enter_s) begin
            if (ex_in_s.load_wen) begin
                state_nxt_s = LD_WAIT;
            end else begin
                state_nxt_s = LD_IDLE;
            end
        end else if (mem_allowin_s) begin
            state_nxt_s = LD_IDLE;
        end else begin
            case (state_r)
                LD_WAIT: begin
                    if (capture_s) begin
                        state_nxt_s = LD_HELD;
                    end else begin
                        state_nxt_s = LD_WAIT;
                    end
                end
                LD_HELD: state_nxt_s = LD_HELD;
                LD_IDLE: state_nxt_s = LD_IDLE;
                default: state_nxt_s = LD_IDLE;
            endcase
        end
    end

    // Stage registers: valid flag, instruction bus, load state and data buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            ex_bus_r    <= '0;
            state_r     <= LD_IDLE;
            data_buf_r  <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (mem_allowin_s) begin
                mem_valid_r <= ex_to_mem_valid;
            end
            if (enter_s) begin
                ex_bus_r <= ex_in_s;
            end
            if (capture_s) begin
                data_buf_r <= Read_data;
            end
        end
    end

    assign raw_s = data_got_s ? data_buf_r : Read_data;

    mem_load_align u_align (
        .raw      (raw_s),
        .offset   (ex_bus_r.result[1:0]),
        .ls_type  (ex_bus_r.ls_type),
        .extended (extended_s)
    );

    assign wb_data_s = ex_bus_r.load_wen ? extended_s : ex_bus_r.result;

    // Outputs that could launch work are suppressed while reset is asserted.
    assign mem_allowin     = mem_allowin_s;
    assign mem_to_wb_valid = mem_valid_r & mem_ready_go_s & !rst;
    assign Read_data_Ready = rd_ready_s & !rst;
    assign mem_to_wb_bus   = {ex_bus_r.wb_wen, ex_bus_r.dest, wb_data_s, ex_bus_r.pc};
    assign rdw_mem_bus     = {mem_ready_go_s, ex_bus_r.wb_wen & mem_valid_r & !rst,
                              ex_bus_r.dest, wb_data_s};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, writeback
// backpressure, back-to-back issue and reset during an outstanding load.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_allowin;
    logic          mem_allowin;
    logic          ex_to_mem_valid;
    logic [107:0]  ex_to_mem_bus;
    logic          mem_to_wb_valid;
    logic [69:0]   mem_to_wb_bus;
    logic [31:0]   Read_data;
    logic          Read_data_Valid;
    logic          Read_data_Ready;
    logic [38:0]   rdw_mem_bus;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .wb_allowin      (wb_allowin),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .rdw_mem_bus     (rdw_mem_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [107:0] mk_ex(input logic [31:0] result, input logic load,
                                           input logic [2:0] ls, input logic wbw,
                                           input logic [4:0] dest, input logic [31:0] pc);
        return {32'hA5A5_5A5A, result, load, 1'b0, ls, 1'b0, wbw, dest, pc};
    endfunction

    function automatic logic [69:0] mk_wb(input logic wbw, input logic [4:0] dest,
                                          input logic [31:0] data, input logic [31:0] pc);
        return {wbw, dest, data, pc};
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Enter a load, wait one cycle, deliver data and check the aligned result.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] ls,
                           input logic [31:0] rdata, input logic [31:0] exp);
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(addr, 1'b1, ls, 1'b1, 5'd3, 32'h0000_0600);
        Read_data_Valid = 1'b0;
        Read_data       = 32'd0;
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk_bit({tag, "_wait_ready"}, Read_data_Ready, 1'b1);
        cyc();
        Read_data       = rdata;
        Read_data_Valid = 1'b1;
        #1;
        chk_bit({tag, "_valid"}, mem_to_wb_valid, 1'b1);
        chk_wb({tag, "_bus"}, mem_to_wb_bus, mk_wb(1'b1, 5'd3, exp, 32'h0000_0600));
    endtask

    initial begin
        rst             = 1'b1;
        wb_allowin      = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_0010, 1'b1, LS_LW, 1'b1, 5'd1, 32'h0000_0000);
        Read_data       = 32'd0;
        Read_data_Valid = 1'b0;

        // Reset held, with a load offered upstream.
        cyc(); cyc();
        #1;
        chk_bit("rst_wb_valid", mem_to_wb_valid, 1'b0);
        chk_bit("rst_rd_ready", Read_data_Ready, 1'b0);
        chk_bit("rst_rdw_wen", rdw_mem_bus[37], 1'b0);
        rst             = 1'b0;
        ex_to_mem_valid = 1'b0;
        cyc();
        #1;
        chk_bit("post_rst_wb_valid", mem_to_wb_valid, 1'b0);
        chk_bit("post_rst_rd_ready", Read_data_Ready, 1'b0);
        chk_bit("post_rst_allowin", mem_allowin, 1'b1);

        // ALU pass-through.
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h1234_5678, 1'b0, LS_LW, 1'b1, 5'd5, 32'h0000_0100);
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk_bit("alu_valid", mem_to_wb_valid, 1'b1);
        chk_wb("alu_bus", mem_to_wb_bus, mk_wb(1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100));
        chk_bit("alu_rd_ready", Read_data_Ready, 1'b0);
        chk_bit("alu_rdw_ready", rdw_mem_bus[38], 1'b1);
        chk_bit("alu_rdw_wen", rdw_mem_bus[37], 1'b1);
        cyc();
        #1;
        chk_bit("alu_one_cycle", mem_to_wb_valid, 1'b0);

        // LB at offset 3, data two cycles after entry.
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_1003, 1'b1, LS_LB, 1'b1, 5'd7, 32'h0000_0200);
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk_bit("lb_wait_ready", Read_data_Ready, 1'b1);
        chk_bit("lb_wait_valid", mem_to_wb_valid, 1'b0);
        chk_bit("lb_wait_rdw_ready", rdw_mem_bus[38], 1'b0);
        chk_bit("lb_wait_allowin", mem_allowin, 1'b0);
        cyc();
        Read_data       = 32'h80FF_0011;
        Read_data_Valid = 1'b1;
        #1;
        chk_bit("lb_arrive_valid", mem_to_wb_valid, 1'b1);
        chk_bit("lb_arrive_rdw_ready", rdw_mem_bus[38], 1'b1);
        chk_wb("lb_bus", mem_to_wb_bus, mk_wb(1'b1, 5'd7, 32'hFFFF_FF80, 32'h0000_0200));
        cyc();
        Read_data_Valid = 1'b0;
        #1;
        chk_bit("lb_done_valid", mem_to_wb_valid, 1'b0);
        chk_bit("lb_done_ready", Read_data_Ready, 1'b0);

        // Alignment / extension variants.
        do_load("lhu_off2", 32'h0000_2002, LS_LHU, 32'h8001_1234, 32'h0000_8001);
        do_load("lh_off2",  32'h0000_2002, LS_LH,  32'h8001_1234, 32'hFFFF_8001);
        do_load("lbu_off2", 32'h0000_2002, LS_LBU, 32'h80FF_0011, 32'h0000_00FF);
        do_load("lb_off1",  32'h0000_2001, LS_LB,  32'h1234_7F56, 32'h0000_007F);
        do_load("lh_off0",  32'h0000_2000, LS_LH,  32'h0000_F00D, 32'hFFFF_F00D);
        do_load("lw_off0",  32'h0000_2000, LS_LW,  32'hC001_D00D, 32'hC001_D00D);
        do_load("ls_bad",   32'h0000_2000, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000);

        // LW under writeback backpressure: data buffered, later Read_data ignored.
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_3000, 1'b1, LS_LW, 1'b1, 5'd9, 32'h0000_0300);
        Read_data_Valid = 1'b0;
        cyc();
        ex_to_mem_valid = 1'b0;
        wb_allowin      = 1'b0;
        #1;
        chk_bit("bp_wait_ready", Read_data_Ready, 1'b1);
        cyc();
        Read_data       = 32'hDEAD_BEEF;
        Read_data_Valid = 1'b1;
        #1;
        chk_bit("bp_arrive_valid", mem_to_wb_valid, 1'b1);
        chk_bit("bp_arrive_allowin", mem_allowin, 1'b0);
        cyc();
        Read_data       = 32'h1111_1111;
        Read_data_Valid = 1'b1;
        #1;
        chk_bit("bp_held_ready", Read_data_Ready, 1'b0);
        chk_bit("bp_held_allowin", mem_allowin, 1'b0);
        chk_bit("bp_held_valid", mem_to_wb_valid, 1'b1);
        chk_wb("bp_held_bus1", mem_to_wb_bus, mk_wb(1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_0300));
        cyc();
        Read_data       = 32'h2222_2222;
        Read_data_Valid = 1'b0;
        #1;
        chk_bit("bp_held_allowin2", mem_allowin, 1'b0);
        chk_wb("bp_held_bus2", mem_to_wb_bus, mk_wb(1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_0300));
        cyc();
        wb_allowin = 1'b1;
        #1;
        chk_bit("bp_release_allowin", mem_allowin, 1'b1);
        chk_bit("bp_release_valid", mem_to_wb_valid, 1'b1);
        chk_wb("bp_release_bus", mem_to_wb_bus, mk_wb(1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_0300));
        cyc();
        #1;
        chk_bit("bp_done_valid", mem_to_wb_valid, 1'b0);

        // Back-to-back: ALU op enters in the load's data-arrival cycle.
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_4000, 1'b1, LS_LW, 1'b1, 5'd10, 32'h0000_0400);
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk_bit("b2b_wait_allowin", mem_allowin, 1'b0);
        cyc();
        Read_data       = 32'hCAFE_F00D;
        Read_data_Valid = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_55AA, 1'b0, LS_LW, 1'b1, 5'd11, 32'h0000_0404);
        #1;
        chk_bit("b2b_arrive_allowin", mem_allowin, 1'b1);
        chk_bit("b2b_load_valid", mem_to_wb_valid, 1'b1);
        chk_wb("b2b_load_bus", mem_to_wb_bus, mk_wb(1'b1, 5'd10, 32'hCAFE_F00D, 32'h0000_0400));
        cyc();
        ex_to_mem_valid = 1'b0;
        Read_data_Valid = 1'b0;
        Read_data       = 32'd0;
        #1;
        chk_bit("b2b_alu_valid", mem_to_wb_valid, 1'b1);
        chk_wb("b2b_alu_bus", mem_to_wb_bus, mk_wb(1'b1, 5'd11, 32'h0000_55AA, 32'h0000_0404));
        chk_bit("b2b_alu_ready", Read_data_Ready, 1'b0);
        cyc();
        #1;
        chk_bit("b2b_done_valid", mem_to_wb_valid, 1'b0);

        // Reset during WAIT; a late response must be ignored.
        cyc();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_ex(32'h0000_5000, 1'b1, LS_LW, 1'b1, 5'd12, 32'h0000_0500);
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk_bit("rstw_wait_ready", Read_data_Ready, 1'b1);
        chk_bit("rstw_wait_wen", rdw_mem_bus[37], 1'b1);
        cyc();
        rst = 1'b1;
        #1;
        chk_bit("rstw_held_ready", Read_data_Ready, 1'b0);
        chk_bit("rstw_held_valid", mem_to_wb_valid, 1'b0);
        chk_bit("rstw_held_wen", rdw_mem_bus[37], 1'b0);
        cyc();
        rst             = 1'b0;
        Read_data       = 32'h1212_1212;
        Read_data_Valid = 1'b1;
        #1;
        chk_bit("rstw_late_valid", mem_to_wb_valid, 1'b0);
        chk_bit("rstw_late_ready", Read_data_Ready, 1'b0);
        chk_bit("rstw_late_wen", rdw_mem_bus[37], 1'b0);
        chk_bit("rstw_late_allowin", mem_allowin, 1'b1);
        cyc();
        Read_data_Valid = 1'b0;
        #1;
        chk_bit("rstw_after_valid", mem_to_wb_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of writeback.
- Accepts the execute-to-mem bus. For loads, it waits for the read-data response of a memory request that was already accepted upstream. It then aligns and extends the loaded value and forwards the result to writeback.
- Drives the read-after-write forwarding/stall bus back to decode.
- Stores and ALU ops pass through in one cycle. Loads hold the stage until data returns, with a one-entry buffer so returned data is never lost under writeback backpressure.

Parameters:
- EX_TO_MEM_BUS_WD, 108, width of the incoming bus.
- MEM_TO_WB_BUS_WD, 70, width of the outgoing bus.
- RDW_BUS_WD, 39, width of the forwarding bus.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wb_allowin  in  1  writeback can accept
- mem_allowin  out  1  this stage can accept
- ex_to_mem_valid  in  1  upstream bus valid
- ex_to_mem_bus  in  108  {rs2_value[107:76], result[75:44], load_wen[43], store_wen[42], ls_type[41:39], mem_wen[38], wb_wen[37], dest[36:32], pc[31:0]}
- mem_to_wb_valid  out  1  downstream bus valid
- mem_to_wb_bus  out  70  {wb_wen[69], dest[68:64], wb_data[63:32], pc[31:0]}
- Read_data  in  32  memory read word
- Read_data_Valid  in  1  read word present
- Read_data_Ready  out  1  stage accepts read word
- rdw_mem_bus  out  39  {data_ready[38], wen[37], dest[36:32], data[31:0]}

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, mem_valid=0, data_got=0 and data_buf=0. mem_to_wb_valid=0, Read_data_Ready=0 and rdw_mem_bus[37]=0 while reset is held and on the first cycle after it.
- Handshake: mem_allowin = !mem_valid | (mem_ready_go & wb_allowin). mem_to_wb_valid = mem_valid & mem_ready_go.
- Pipeline register: on mem_allowin, mem_valid <= ex_to_mem_valid. The bus register is loaded only when ex_to_mem_valid & mem_allowin.
- mem_ready_go = !load_wen | data_got | Read_data_Valid.
- Read_data_Ready = mem_valid & load_wen & !data_got. When Ready is low, Read_data_Valid is ignored.
- Load capture: when Read_data_Valid & Read_data_Ready & !wb_allowin, set data_got=1 and data_buf<=Read_data (state WAIT -> HELD).
- Clearing data_got: data_got clears when the stage hands off (mem_to_wb_valid & wb_allowin) or when a new instruction enters. Both can happen in one cycle; the result is a clear, never a set.
- Pass-through on arrival: Read_data_Valid in the same cycle as wb_allowin passes straight through and is not buffered.
- Load states per instruction: IDLE (no valid) -> WAIT (load valid, no data) -> HELD (data buffered) -> leave.
  - Non-loads go IDLE -> leave in the same cycle they are valid, provided wb_allowin is high.
- Load word source: raw = data_got ? data_buf : Read_data. Byte offset = result[1:0].
  - ls_type 000 LB: byte raw[8*off+7 : 8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half raw[16*off[1]+15 : 16*off[1]], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: raw.
  - Other encodings: 0.
- Misaligned halves/words: not checked; the aligned word is used as above.
- wb_data = load_wen ? extended : result.
- Stores: wb_wen=0 expected from decode. wb_wen is passed through unchanged; the stage does not force it.
- rdw_mem_bus: data_ready = !load_wen | data_got | Read_data_Valid. wen = wb_wen & mem_valid. data = wb_data.
- Reset mid-load: the pending response is dropped, data_got is cleared, and no output is produced.
- Latency: non-load is 0 extra cycles (registered once). Load is N cycles until Read_data_Valid, plus 0.

Decomposition:
- Bus widths and bus field positions go in the shared header as macros: EX_TO_MEM_BUS_WD, MEM_TO_WB_BUS_WD, RDW_BUS_WD.
- ls_type encodings are defined as named constants in the same header.
- One combinational sub-module, mem_load_align: inputs raw word, offset and ls_type; output is the extended 32-bit value.

Test Plan:
- ALU pass-through: result=0x1234_5678, wb_wen=1, dest=5, wb_allowin=1 -> next cycle mem_to_wb_bus wb_data=0x1234_5678, dest=5, one-cycle valid; Read_data_Ready stays 0.
- LB at offset 3, Read_data=0x80FF_0011, Valid two cycles after entry -> wb_data=0xFFFF_FF80. The rdw data_ready bit is 0 while waiting and 1 in the arrival cycle.
- LHU at offset 2, Read_data=0x8001_xxxx -> wb_data=0x0000_8001. LH at the same offset -> 0xFFFF_8001.
- Backpressure: LW with wb_allowin=0 when Read_data=0xDEAD_BEEF arrives, Read_data changes afterwards, wb_allowin rises 3 cycles later -> wb_data=0xDEAD_BEEF. Read_data_Ready is 0 while HELD; mem_allowin is 0 until handoff.
- Back-to-back: LW followed by an ALU op, wb_allowin=1 -> the ALU op enters in the cycle the load data arrives, data_got never sets, and both reach writeback in consecutive cycles.
- rst asserted during WAIT -> mem_to_wb_valid=0 and Read_data_Ready=0 next cycle. A late Read_data_Valid is ignored and produces no writeback.
